// File: rtl/jtag_pkg.sv
// Shared types and widths for the core-clock debug access scheduler.
package jtag_pkg;

   localparam int DBG_ADDR_W = 32;
   localparam int DBG_DATA_W = 32;

   // Scheduler FSM encoding
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_HALT_WAIT = 3'd1,
      ST_ACCESS    = 3'd2,
      ST_RSP_WAIT  = 3'd3,
      ST_DONE      = 3'd4,
      ST_RESET     = 3'd5
   } sched_state_e;

   // Largest of three values; sizes the shared timeout counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Loadable saturating up-counter with a terminal-count flag.
module dbg_timeout_cnt #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic [W-1:0] term_val,
   output logic         term
);

   logic [W-1:0] cnt;

   // Count up from the load value, sticking at all-ones
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (ld)
         cnt <= ld_val;
      else if (cnt != '1)
         cnt <= cnt + 1'b1;
   end

   assign term = (cnt == term_val);

endmodule

// File: rtl/jtag_access_sched.sv
// Halts the core, runs one debug memory transaction on the shared port,
// and sequences debugger-requested core reset pulses.
module jtag_access_sched
   import jtag_pkg::*;
#(
   parameter int HALT_TIMEOUT = 64,
   parameter int RSP_TIMEOUT  = 64,
   parameter int RST_CYCLES   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dbg_req_i,
   input  logic                  dbg_we_i,
   input  logic [DBG_ADDR_W-1:0] dbg_addr_i,
   input  logic [DBG_DATA_W-1:0] dbg_wdata_i,
   output logic                  dbg_ack_o,
   output logic [DBG_DATA_W-1:0] dbg_rdata_o,
   output logic                  dbg_err_o,
   input  logic                  dbg_halt_i,
   input  logic                  dbg_reset_i,
   output logic                  core_halt_o,
   input  logic                  core_halted_i,
   output logic                  core_rst_o,
   input  logic                  core_req_i,
   output logic                  core_gnt_o,
   output logic                  dbg_owns_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [DBG_ADDR_W-1:0] mem_addr_o,
   output logic [DBG_DATA_W-1:0] mem_wdata_o,
   input  logic [DBG_DATA_W-1:0] mem_rdata_i,
   input  logic                  mem_rvalid_i
);

   localparam int CNT_W = $clog2(max3(HALT_TIMEOUT, RSP_TIMEOUT, RST_CYCLES) + 1);

   sched_state_e state, state_nxt;
   logic             armed, rst_d, rst_edge;
   logic             latch, cap_rd, fin_ok, fin_err, abort, ack_d;
   logic             cnt_ld, cnt_term;
   logic [CNT_W-1:0] term_val;

   assign rst_edge   = dbg_reset_i & ~rst_d;
   assign core_gnt_o = core_req_i & ~dbg_owns_o & ~core_rst_o;

   // One counter shared by HALT_WAIT, RSP_WAIT and RESET; zeroed on every state change
   dbg_timeout_cnt #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .ld       (cnt_ld),
      .ld_val   ('0),
      .term_val (term_val),
      .term     (cnt_term)
   );

   // Next-state and completion decode; a reset edge overrides everything
   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      cap_rd    = 1'b0;
      fin_ok    = 1'b0;
      fin_err   = 1'b0;
      abort     = 1'b0;
      term_val  = '1;
      case (state)
         ST_IDLE: begin
            if (dbg_req_i && armed) begin
               state_nxt = ST_HALT_WAIT;
               latch     = 1'b1;
            end
         end
         ST_HALT_WAIT: begin
            term_val = CNT_W'(HALT_TIMEOUT - 1);
            if (core_halted_i)
               state_nxt = ST_ACCESS;
            else if (cnt_term) begin
               state_nxt = ST_DONE;
               fin_err   = 1'b1;
            end
         end
         ST_ACCESS: state_nxt = ST_RSP_WAIT;
         ST_RSP_WAIT: begin
            term_val = CNT_W'(RSP_TIMEOUT - 1);
            if (mem_rvalid_i) begin
               state_nxt = ST_DONE;
               fin_ok    = 1'b1;
               cap_rd    = ~mem_we_o;
            end else if (cnt_term) begin
               state_nxt = ST_DONE;
               fin_err   = 1'b1;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         ST_RESET: begin
            term_val = CNT_W'(RST_CYCLES - 1);
            if (cnt_term)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (rst_edge) begin
         abort     = (state == ST_HALT_WAIT) || (state == ST_ACCESS) || (state == ST_RSP_WAIT);
         state_nxt = ST_RESET;
         latch     = 1'b0;
         cap_rd    = 1'b0;
         fin_ok    = 1'b0;
         fin_err   = 1'b0;
      end
      ack_d  = fin_ok | fin_err | abort;
      cnt_ld = (state_nxt != state) || rst_edge;
   end

   // State, registered outputs, request latch and re-arm tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         armed       <= 1'b1;
         rst_d       <= 1'b0;
         dbg_ack_o   <= 1'b0;
         dbg_err_o   <= 1'b0;
         dbg_rdata_o <= '0;
         core_halt_o <= 1'b0;
         core_rst_o  <= 1'b0;
         dbg_owns_o  <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         state       <= state_nxt;
         rst_d       <= dbg_reset_i;
         dbg_ack_o   <= ack_d;
         core_halt_o <= dbg_halt_i | (state_nxt inside {ST_HALT_WAIT, ST_ACCESS, ST_RSP_WAIT, ST_DONE});
         core_rst_o  <= (state_nxt == ST_RESET);
         dbg_owns_o  <= (state_nxt == ST_ACCESS) || (state_nxt == ST_RSP_WAIT);
         mem_req_o   <= (state_nxt == ST_ACCESS);
         if (ack_d)
            dbg_err_o <= fin_err | abort;
         if (cap_rd)
            dbg_rdata_o <= mem_rdata_i;
         if (latch) begin
            mem_we_o    <= dbg_we_i;
            mem_addr_o  <= dbg_addr_i;
            mem_wdata_o <= dbg_wdata_i;
         end
         // A level request that spans its own ack must drop before it counts again
         if (!dbg_req_i)
            armed <= 1'b1;
         else if (dbg_ack_o)
            armed <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtag_access_sched.sv
// Directed bench for jtag_access_sched: IDLE vector table plus transaction sequences.
module tb_jtag_access_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        dbg_req_i, dbg_we_i, dbg_halt_i, dbg_reset_i;
   logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
   logic        dbg_ack_o, dbg_err_o;
   logic        core_halt_o, core_halted_i, core_rst_o, core_req_i, core_gnt_o;
   logic        dbg_owns_o, mem_req_o, mem_we_o, mem_rvalid_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   always #5 clk = ~clk;

   jtag_access_sched dut (
      .clk(clk), .rst(rst),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
      .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
      .dbg_halt_i(dbg_halt_i), .dbg_reset_i(dbg_reset_i),
      .core_halt_o(core_halt_o), .core_halted_i(core_halted_i), .core_rst_o(core_rst_o),
      .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .dbg_owns_o(dbg_owns_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Memory model: latency counts RSP_WAIT cycles before rvalid; -1 never answers
   int          mem_lat = -1;
   logic [31:0] mem_rd_val = 32'h0;
   int          nreq = 0;
   logic [31:0] seen_addr, seen_wdata;
   logic        seen_we;
   bit          pend = 1'b0;
   int          wcnt = 0;
   int          viol = 0;
   int          owns_seen = 0;

   // Responds away from the active edge, also watching grant exclusivity
   always @(negedge clk) begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = mem_rd_val;
      if (pend) begin
         if (wcnt == 0) begin
            mem_rvalid_i = 1'b1;
            pend = 1'b0;
         end else
            wcnt--;
      end
      if (mem_req_o) begin
         nreq++;
         seen_addr  = mem_addr_o;
         seen_wdata = mem_wdata_o;
         seen_we    = mem_we_o;
         if (mem_lat >= 0) begin
            pend = 1'b1;
            wcnt = mem_lat;
         end
      end
      if (dbg_owns_o) begin
         owns_seen++;
         if (core_gnt_o) viol++;
      end
   end

   typedef struct {
      string nm;
      logic  core_req;
      logic  halt;
      logic  exp_gnt;
      logic  exp_halt;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      dbg_we_i    = we;
      dbg_addr_i  = addr;
      dbg_wdata_i = wdata;
      dbg_req_i   = 1'b1;
   endtask

   // Cycles from request to ack; -1 if none within the budget
   task automatic wait_ack(input string nm, input int maxc, output int cyc);
      cyc = -1;
      for (int i = 1; i <= maxc; i++) begin
         tick();
         if (dbg_ack_o) begin
            cyc = i;
            break;
         end
      end
      chk1({nm, "_ack_seen"}, cyc > 0, 1'b1);
   endtask

   task automatic drop_req();
      dbg_req_i = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, n0, acks, rc;

      vecs[0] = '{"idle_none",  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"idle_creq",  1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{"idle_halt",  1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{"idle_both",  1'b1, 1'b1, 1'b1, 1'b1};

      rst = 1'b1;
      dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
      dbg_halt_i = 0; dbg_reset_i = 0; core_halted_i = 0; core_req_i = 0;
      repeat (3) tick();
      chk1("rst_ack", dbg_ack_o, 1'b0);
      chk1("rst_err", dbg_err_o, 1'b0);
      chk ("rst_rdata", dbg_rdata_o, 32'h0);
      chk1("rst_halt", core_halt_o, 1'b0);
      chk1("rst_core_rst", core_rst_o, 1'b0);
      chk1("rst_owns", dbg_owns_o, 1'b0);
      chk1("rst_mem_req", mem_req_o, 1'b0);
      chk ("rst_mem_addr", mem_addr_o, 32'h0);
      rst = 1'b0;
      tick();

      // IDLE: combinational grant and registered halt follow the inputs
      for (int i = 0; i < 4; i++) begin
         core_req_i = vecs[i].core_req;
         dbg_halt_i = vecs[i].halt;
         #1;
         chk1({vecs[i].nm, "_gnt"}, core_gnt_o, vecs[i].exp_gnt);
         tick();
         chk1({vecs[i].nm, "_halt"}, core_halt_o, vecs[i].exp_halt);
      end
      core_req_i = 0; dbg_halt_i = 0;
      tick();

      // Read with the core already halted: 4 + 2 cycles to ack
      core_halted_i = 1; mem_lat = 2; mem_rd_val = 32'hDEADBEEF;
      n0 = nreq;
      start_req(1'b0, 32'h1000, 32'h0);
      wait_ack("rd", 20, cyc);
      chk ("rd_latency", cyc, 32'd6);
      chk ("rd_rdata", dbg_rdata_o, 32'hDEADBEEF);
      chk1("rd_err", dbg_err_o, 1'b0);
      chk ("rd_nreq", nreq - n0, 32'd1);
      chk ("rd_addr", seen_addr, 32'h1000);
      drop_req();

      // Write with a late halt and a competing core master
      core_halted_i = 0; core_req_i = 1; mem_lat = 1; mem_rd_val = 32'h0BAD0BAD;
      viol = 0; owns_seen = 0; n0 = nreq;
      start_req(1'b1, 32'h2000, 32'h12345678);
      #1;
      chk1("wr_same_cycle_gnt", core_gnt_o, 1'b1);
      tick();
      chk1("wr_halt_req", core_halt_o, 1'b1);
      repeat (9) tick();
      chk ("wr_no_early_req", nreq - n0, 32'd0);
      core_halted_i = 1;
      wait_ack("wr", 30, cyc);
      chk ("wr_nreq", nreq - n0, 32'd1);
      chk ("wr_addr", seen_addr, 32'h2000);
      chk ("wr_wdata", seen_wdata, 32'h12345678);
      chk1("wr_we", seen_we, 1'b1);
      chk1("wr_err", dbg_err_o, 1'b0);
      chk ("wr_gnt_excl", viol, 32'd0);
      chk1("wr_owned", owns_seen > 0, 1'b1);
      chk ("wr_rdata_kept", dbg_rdata_o, 32'hDEADBEEF);
      core_req_i = 0;
      drop_req();

      // Core never halts: timeout after 64 HALT_WAIT cycles
      core_halted_i = 0; mem_lat = 2; n0 = nreq;
      start_req(1'b0, 32'h3000, 32'h0);
      wait_ack("halt_to", 200, cyc);
      chk ("halt_to_latency", cyc, 32'd65);
      chk1("halt_to_err", dbg_err_o, 1'b1);
      chk ("halt_to_no_req", nreq - n0, 32'd0);
      drop_req();

      // Memory never answers: timeout after 64 RSP_WAIT cycles, rdata kept
      core_halted_i = 1; mem_lat = -1;
      start_req(1'b0, 32'h4000, 32'h0);
      wait_ack("rsp_to", 200, cyc);
      chk ("rsp_to_latency", cyc, 32'd67);
      chk1("rsp_to_err", dbg_err_o, 1'b1);
      chk ("rsp_to_rdata", dbg_rdata_o, 32'hDEADBEEF);
      drop_req();

      // Request held across its ack: no re-issue until it drops
      mem_lat = 0; mem_rd_val = 32'hCAFEF00D; n0 = nreq;
      start_req(1'b0, 32'h5000, 32'h0);
      wait_ack("hold1", 20, cyc);
      chk ("hold1_rdata", dbg_rdata_o, 32'hCAFEF00D);
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dbg_ack_o) acks++;
      end
      chk ("hold_no_reack", acks, 32'd0);
      chk ("hold_one_req", nreq - n0, 32'd1);
      drop_req();
      dbg_req_i = 1'b1;
      wait_ack("hold2", 20, cyc);
      chk ("hold_second_req", nreq - n0, 32'd2);
      drop_req();

      // Reset edge during RSP_WAIT: abort ack then a 16-cycle core reset
      mem_lat = -1;
      start_req(1'b0, 32'h6000, 32'h0);
      repeat (4) tick();
      chk1("dr_in_rsp", dbg_owns_o, 1'b1);
      dbg_reset_i = 1'b1;
      tick();
      chk1("dr_ack", dbg_ack_o, 1'b1);
      chk1("dr_err", dbg_err_o, 1'b1);
      chk1("dr_core_rst", core_rst_o, 1'b1);
      dbg_req_i = 1'b0;
      rc = 1; acks = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dbg_ack_o) acks++;
         if (core_rst_o) rc++;
         else break;
      end
      chk ("dr_pulse_len", rc, 32'd16);
      chk ("dr_single_ack", acks, 32'd0);
      chk1("dr_idle_owns", dbg_owns_o, 1'b0);
      chk1("dr_idle_halt", core_halt_o, 1'b0);
      dbg_reset_i = 1'b0;
      tick();

      // Synchronous reset mid-access: no ack ever appears
      start_req(1'b0, 32'h7000, 32'h0);
      repeat (4) tick();
      chk1("mr_in_rsp", dbg_owns_o, 1'b1);
      rst = 1'b1; dbg_req_i = 1'b0;
      tick();
      chk1("mr_owns", dbg_owns_o, 1'b0);
      chk1("mr_halt", core_halt_o, 1'b0);
      chk1("mr_ack", dbg_ack_o, 1'b0);
      rst = 1'b0;
      acks = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (dbg_ack_o) acks++;
      end
      chk ("mr_no_ack", acks, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
